// File: rtl/traffic_ctrl_multi.sv
// Round-robin intersection controller: GREEN -> YELLOW -> ALL_RED per approach,
// with latched pedestrian walk service and a night flashing-yellow mode.
module traffic_ctrl_multi #(
    parameter int NUM_DIR = 2,
    parameter int CNT_W   = 8,
    parameter int FLASH_T = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   tick,
    input  logic                   night_mode,
    input  logic [CNT_W-1:0]       green_time,
    input  logic [CNT_W-1:0]       yellow_time,
    input  logic [CNT_W-1:0]       allred_time,
    input  logic [NUM_DIR-1:0]     ped_req,
    output logic [3*NUM_DIR-1:0]   light,
    output logic [NUM_DIR-1:0]     walk,
    output logic [1:0]             active_dir,
    output logic [CNT_W-1:0]       remain,
    output logic                   phase_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_ALLRED = 3'd3,
        ST_FLASH  = 3'd4
    } state_t;

    localparam logic [1:0]       LAST_DIR   = 2'(NUM_DIR - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_T - 1);
    localparam logic [2:0]       LAMP_R     = 3'b100;
    localparam logic [2:0]       LAMP_Y     = 3'b010;
    localparam logic [2:0]       LAMP_G     = 3'b001;
    localparam logic [2:0]       LAMP_OFF   = 3'b000;

    // A duration of zero is served as a single tick.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] dur);
        if (dur == '0) begin
            load_val = '0;
        end else begin
            load_val = dur - CNT_W'(1);
        end
    endfunction

    function automatic logic [NUM_DIR-1:0] dir_mask(input logic [1:0] dir);
        dir_mask = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            if (int'(dir) == d) begin
                dir_mask[d] = 1'b1;
            end else begin
                dir_mask[d] = 1'b0;
            end
        end
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          dir_q, dir_d;
    logic [NUM_DIR-1:0]  ped_q, ped_d;
    logic                walk_q, walk_d;
    logic                flash_y_q, flash_y_d;
    logic                done_s;
    logic                go_green_s;
    logic [1:0]          green_dir_s;
    logic                end_s;
    logic [1:0]          next_dir_s;
    logic [NUM_DIR-1:0]  ped_set_s;

    assign end_s      = tick && (cnt_q == '0);
    assign next_dir_s = (dir_q == LAST_DIR) ? 2'd0 : dir_q + 2'd1;
    assign ped_set_s  = ped_q | ped_req;

    // Next-state, counter, direction and pedestrian-latch logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        ped_d       = ped_set_s;
        walk_d      = walk_q;
        flash_y_d   = flash_y_q;
        done_s      = 1'b0;
        go_green_s  = 1'b0;
        green_dir_s = 2'd0;
        if (!en) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            dir_d     = 2'd0;
            ped_d     = '0;
            walk_d    = 1'b0;
            flash_y_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    go_green_s  = 1'b1;
                    green_dir_s = 2'd0;
                end
                ST_GREEN: begin
                    if (end_s) begin
                        done_s  = 1'b1;
                        state_d = ST_YELLOW;
                        cnt_d   = load_val(yellow_time);
                        walk_d  = 1'b0;
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_YELLOW: begin
                    if (end_s) begin
                        done_s  = 1'b1;
                        state_d = ST_ALLRED;
                        cnt_d   = load_val(allred_time);
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_ALLRED: begin
                    if (end_s && night_mode) begin
                        done_s    = 1'b1;
                        state_d   = ST_FLASH;
                        cnt_d     = FLASH_LOAD;
                        flash_y_d = 1'b1;
                    end else if (end_s) begin
                        done_s      = 1'b1;
                        go_green_s  = 1'b1;
                        green_dir_s = next_dir_s;
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_FLASH: begin
                    // Leaving via ALL_RED with dir parked at the last approach
                    // makes the following GREEN wrap to approach 0.
                    if (end_s && !night_mode) begin
                        done_s    = 1'b1;
                        state_d   = ST_ALLRED;
                        cnt_d     = load_val(allred_time);
                        dir_d     = LAST_DIR;
                        flash_y_d = 1'b0;
                    end else if (end_s) begin
                        cnt_d     = FLASH_LOAD;
                        flash_y_d = ~flash_y_q;
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (go_green_s) begin
                state_d = ST_GREEN;
                dir_d   = green_dir_s;
                cnt_d   = load_val(green_time);
                walk_d  = |(ped_set_s & dir_mask(green_dir_s));
                ped_d   = ped_set_s & ~dir_mask(green_dir_s);
            end else begin
                walk_d = walk_d;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dir_q     <= 2'd0;
            ped_q     <= '0;
            walk_q    <= 1'b0;
            flash_y_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            ped_q     <= ped_d;
            walk_q    <= walk_d;
            flash_y_q <= flash_y_d;
        end
    end

    // Lamp and walk decode from the registered state.
    always_comb begin
        light = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            case (state_q)
                ST_GREEN:  light[3*d +: 3] = (int'(dir_q) == d) ? LAMP_G : LAMP_R;
                ST_YELLOW: light[3*d +: 3] = (int'(dir_q) == d) ? LAMP_Y : LAMP_R;
                ST_ALLRED: light[3*d +: 3] = LAMP_R;
                ST_FLASH:  light[3*d +: 3] = flash_y_q ? LAMP_Y : LAMP_OFF;
                default:   light[3*d +: 3] = LAMP_OFF;
            endcase
        end
        if ((state_q == ST_GREEN) && walk_q) begin
            walk = dir_mask(dir_q);
        end else begin
            walk = '0;
        end
    end

    assign active_dir = dir_q;
    assign remain     = cnt_q;
    assign phase_done = done_s;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi with NUM_DIR=2, CNT_W=8, FLASH_T=2.
module tb_traffic_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       night_mode = 1'b0;
    logic [7:0] green_t = 8'd3;
    logic [7:0] yellow_t = 8'd1;
    logic [7:0] allred_t = 8'd1;
    logic [1:0] ped_req = 2'b00;
    logic [5:0] light;
    logic [1:0] walk;
    logic [1:0] active_dir;
    logic [7:0] remain;
    logic       phase_done;

    int errors = 0;
    int checks = 0;
    logic inv_on = 1'b0;

    traffic_ctrl_multi #(.NUM_DIR(2), .CNT_W(8), .FLASH_T(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .night_mode(night_mode),
        .green_time(green_t), .yellow_time(yellow_t), .allred_time(allred_t),
        .ped_req(ped_req), .light(light), .walk(walk), .active_dir(active_dir),
        .remain(remain), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    function automatic logic lamp_ok(input logic [5:0] l);
        logic [2:0] seg;
        int nonr;
        logic ok;
        nonr = 0;
        ok = 1'b1;
        for (int d = 0; d < 2; d++) begin
            seg = l[3*d +: 3];
            if (seg != 3'b100 && seg != 3'b010 && seg != 3'b001) ok = 1'b0;
            if (seg != 3'b100) nonr++;
        end
        if (nonr > 1) ok = 1'b0;
        return ok;
    endfunction

    // Lamp invariant on every cycle outside IDLE (all off) and FLASH (all Y).
    always @(negedge clk) begin
        if (inv_on && rst_n && light !== 6'b000000 && light !== 6'b010010) begin
            checks++;
            if (lamp_ok(light) !== 1'b1) begin
                errors++;
                $display("FAIL lamp_invariant light=%b", light);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Three quiet cycles then a tick cycle; returns phase_done seen during the tick.
    task automatic do_tick(output logic pd);
        repeat (3) step();
        tick = 1'b1;
        #1;
        pd = phase_done;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic restart();
        en = 1'b0;
        night_mode = 1'b0;
        ped_req = 2'b00;
        step();
        en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        tick = 1'b1;
        #12;
        checks += 5;
        if (light !== 6'b0) begin errors++; $display("FAIL reset_light got=%b exp=%b", light, 6'b0); end
        if (walk !== 2'b0) begin errors++; $display("FAIL reset_walk got=%b exp=%b", walk, 2'b0); end
        if (active_dir !== 2'd0) begin errors++; $display("FAIL reset_dir got=%0d exp=0", active_dir); end
        if (remain !== 8'd0) begin errors++; $display("FAIL reset_remain got=%0d exp=0", remain); end
        if (phase_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", phase_done); end
        tick = 1'b0;
        rst_n = 1'b1;
        step();
        inv_on = 1'b1;
    endtask

    task automatic test_basic_cycle();
        logic [5:0] exp_l [10] = '{6'b100001, 6'b100001, 6'b100010, 6'b100100, 6'b001100,
                                   6'b001100, 6'b001100, 6'b010100, 6'b100100, 6'b100001};
        logic       exp_pd [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_d [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        logic [7:0] exp_r [10] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd2};
        logic pd;
        green_t = 8'd3; yellow_t = 8'd1; allred_t = 8'd1;
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        checks += 3;
        if (light !== 6'b100001) begin errors++; $display("FAIL basic_entry_light got=%b exp=%b", light, 6'b100001); end
        if (remain !== 8'd2) begin errors++; $display("FAIL basic_entry_remain got=%0d exp=2", remain); end
        if (active_dir !== 2'd0) begin errors++; $display("FAIL basic_entry_dir got=%0d exp=0", active_dir); end
        for (int k = 0; k < 10; k++) begin
            do_tick(pd);
            checks += 5;
            if (pd !== exp_pd[k]) begin errors++; $display("FAIL basic_done t%0d got=%b exp=%b", k+1, pd, exp_pd[k]); end
            if (light !== exp_l[k]) begin errors++; $display("FAIL basic_light t%0d got=%b exp=%b", k+1, light, exp_l[k]); end
            if (active_dir !== exp_d[k]) begin errors++; $display("FAIL basic_dir t%0d got=%0d exp=%0d", k+1, active_dir, exp_d[k]); end
            if (remain !== exp_r[k]) begin errors++; $display("FAIL basic_remain t%0d got=%0d exp=%0d", k+1, remain, exp_r[k]); end
            if (walk !== 2'b00) begin errors++; $display("FAIL basic_walk t%0d got=%b exp=00", k+1, walk); end
        end
    endtask

    task automatic test_zero_durations();
        logic [5:0] exp_l [4] = '{6'b100001, 6'b100010, 6'b100100, 6'b001100};
        logic       exp_pd [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_r [4] = '{8'd0, 8'd0, 8'd0, 8'd1};
        logic pd;
        green_t = 8'd2; yellow_t = 8'd0; allred_t = 8'd0;
        restart();
        checks++;
        if (remain !== 8'd1) begin errors++; $display("FAIL zero_entry_remain got=%0d exp=1", remain); end
        for (int k = 0; k < 4; k++) begin
            do_tick(pd);
            checks += 3;
            if (pd !== exp_pd[k]) begin errors++; $display("FAIL zero_done t%0d got=%b exp=%b", k+1, pd, exp_pd[k]); end
            if (light !== exp_l[k]) begin errors++; $display("FAIL zero_light t%0d got=%b exp=%b", k+1, light, exp_l[k]); end
            if (remain !== exp_r[k]) begin errors++; $display("FAIL zero_remain t%0d got=%0d exp=%0d", k+1, remain, exp_r[k]); end
        end
    endtask

    task automatic test_ped();
        logic pd;
        logic [1:0] exp_w;
        green_t = 8'd3; yellow_t = 8'd1; allred_t = 8'd1;
        restart();
        for (int k = 1; k <= 25; k++) begin
            if (k == 1 || k == 6) begin
                ped_req = 2'b10;
                step();
                ped_req = 2'b00;
                checks++;
                if (walk !== (k == 6 ? 2'b10 : 2'b00)) begin
                    errors++; $display("FAIL ped_walk_pulse k%0d got=%b", k, walk);
                end
            end
            do_tick(pd);
            exp_w = (k inside {5, 6, 7, 15, 16, 17}) ? 2'b10 : 2'b00;
            checks++;
            if (walk !== exp_w) begin errors++; $display("FAIL ped_walk t%0d got=%b exp=%b", k, walk, exp_w); end
        end
    endtask

    task automatic test_night();
        logic [5:0] exp_l [12] = '{6'b100001, 6'b100001, 6'b100010, 6'b100100, 6'b010010, 6'b010010,
                                   6'b000000, 6'b000000, 6'b010010, 6'b010010, 6'b100100, 6'b100001};
        logic       exp_pd [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp_r [12] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd2};
        logic pd;
        logic [1:0] exp_w;
        green_t = 8'd3; yellow_t = 8'd1; allred_t = 8'd1;
        restart();
        night_mode = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) begin
                ped_req = 2'b01;
                step();
                ped_req = 2'b00;
            end
            if (k == 10) night_mode = 1'b0;
            do_tick(pd);
            exp_w = (k == 12) ? 2'b01 : 2'b00;
            checks += 4;
            if (pd !== exp_pd[k-1]) begin errors++; $display("FAIL night_done t%0d got=%b exp=%b", k, pd, exp_pd[k-1]); end
            if (light !== exp_l[k-1]) begin errors++; $display("FAIL night_light t%0d got=%b exp=%b", k, light, exp_l[k-1]); end
            if (remain !== exp_r[k-1]) begin errors++; $display("FAIL night_remain t%0d got=%0d exp=%0d", k, remain, exp_r[k-1]); end
            if (walk !== exp_w) begin errors++; $display("FAIL night_walk t%0d got=%b exp=%b", k, walk, exp_w); end
        end
        checks++;
        if (active_dir !== 2'd0) begin errors++; $display("FAIL night_exit_dir got=%0d exp=0", active_dir); end
    endtask

    task automatic test_en_drop();
        logic pd;
        green_t = 8'd3; yellow_t = 8'd1; allred_t = 8'd1;
        restart();
        repeat (3) do_tick(pd);
        checks++;
        if (light !== 6'b100010) begin errors++; $display("FAIL endrop_pre_light got=%b exp=%b", light, 6'b100010); end
        en = 1'b0;
        tick = 1'b1;
        #1;
        checks++;
        if (phase_done !== 1'b0) begin errors++; $display("FAIL endrop_done_masked got=%b exp=0", phase_done); end
        @(posedge clk);
        #1;
        tick = 1'b0;
        #1;
        checks += 4;
        if (light !== 6'b0) begin errors++; $display("FAIL endrop_light got=%b exp=0", light); end
        if (walk !== 2'b0) begin errors++; $display("FAIL endrop_walk got=%b exp=0", walk); end
        if (active_dir !== 2'd0) begin errors++; $display("FAIL endrop_dir got=%0d exp=0", active_dir); end
        if (remain !== 8'd0) begin errors++; $display("FAIL endrop_remain got=%0d exp=0", remain); end
        en = 1'b1;
        step();
        checks += 2;
        if (light !== 6'b100001) begin errors++; $display("FAIL endrop_reentry_light got=%b exp=%b", light, 6'b100001); end
        if (remain !== 8'd2) begin errors++; $display("FAIL endrop_reentry_remain got=%0d exp=2", remain); end
    endtask

    task automatic test_reset_mid();
        logic pd;
        green_t = 8'd3; yellow_t = 8'd1; allred_t = 8'd1;
        restart();
        ped_req = 2'b10;
        step();
        ped_req = 2'b00;
        checks++;
        if (remain !== 8'd2) begin errors++; $display("FAIL rstmid_pre_remain got=%0d exp=2", remain); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (light !== 6'b0) begin errors++; $display("FAIL rstmid_light got=%b exp=0", light); end
        if (walk !== 2'b0) begin errors++; $display("FAIL rstmid_walk got=%b exp=0", walk); end
        if (remain !== 8'd0) begin errors++; $display("FAIL rstmid_remain got=%0d exp=0", remain); end
        if (active_dir !== 2'd0) begin errors++; $display("FAIL rstmid_dir got=%0d exp=0", active_dir); end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (light !== 6'b100001) begin errors++; $display("FAIL rstmid_resume_light got=%b exp=%b", light, 6'b100001); end
        repeat (5) do_tick(pd);
        checks += 2;
        if (light !== 6'b001100) begin errors++; $display("FAIL rstmid_dir1_light got=%b exp=%b", light, 6'b001100); end
        if (walk !== 2'b00) begin errors++; $display("FAIL rstmid_dir1_walk got=%b exp=00", walk); end
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_zero_durations();
        test_ped();
        test_night();
        test_en_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Multi-approach intersection signal controller: the parametrised successor to the single-light traffic FSM. It sequences GREEN → YELLOW → ALL_RED across `NUM_DIR` approaches in round-robin order, using an internal phase counter that advances on an external timebase tick. It adds per-approach pedestrian walk service and a night flashing-yellow mode. It sits between the timebase prescaler and the lamp-driver outputs.

## Interface
- `NUM_DIR`, 2: number of approaches (2..4).
- `CNT_W`, 8: width of the phase counter and the duration inputs.
- `FLASH_T`, 2: ticks per half-period of the night flash.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  controller enable; 0 forces IDLE synchronously.
- `tick`  in  1  one-cycle timebase pulse; all durations are counted in ticks.
- `night_mode`  in  1  level request for flashing-yellow operation.
- `green_time`, `yellow_time`, `allred_time`  in  CNT_W each  phase durations in ticks; sampled at phase entry.
- `ped_req`  in  NUM_DIR  pedestrian button per approach; level or pulse.
- `light`  out  3*NUM_DIR  per approach d, bits [3d+2:3d] = {R,Y,G}.
- `walk`  out  NUM_DIR  walk lamp per approach.
- `active_dir`  out  2  index of the approach currently served.
- `remain`  out  CNT_W  ticks left in the current phase.
- `phase_done`  out  1  one-cycle pulse on every phase transition edge.

## Operation
- States: IDLE, GREEN, YELLOW, ALL_RED, FLASH. The state, counter, `active_dir`, and pedestrian latches are registered. `light` and `walk` are decoded combinationally from registers.
- IDLE: all `light`/`walk` = 0; `remain` = 0. On the first cycle with `en`=1, go to GREEN with `active_dir`=0. No tick is needed.
- Phase entry loads the counter with max(dur,1)-1. A duration of 0 behaves as 1.
- The counter decrements only on `tick`. A phase ends on a cycle where `tick`=1 and counter=0; `phase_done` pulses in that cycle.
- In GREEN and YELLOW, `active_dir` shows G or Y and every other approach shows R. ALL_RED: every approach shows R.
- Sequence: GREEN → YELLOW → ALL_RED → GREEN of (`active_dir`+1) mod `NUM_DIR`. The index wraps from `NUM_DIR`-1 to 0.
- Pedestrian latch: `ped_req[d]` sets latch d on any cycle.
- On entry to GREEN of approach d, the latch is transferred to walk-service and latch d is cleared.
- `walk[d]`=1 only for the GREEN phase of d when it has been serviced.
- A request arriving during the GREEN of d is held until d's next GREEN.
- Night mode: `night_mode` is checked only when an ALL_RED phase ends. If it is set, go to FLASH instead of GREEN.
- FLASH: all approaches show Y=1/0, toggling every `FLASH_T` ticks and starting at Y=1. `walk`=0 and the pedestrian latches keep accumulating.
- FLASH exit: when `night_mode`=0 at a toggle boundary, go to ALL_RED (`allred_time`), then GREEN of approach 0.
- `en`=0 in any state: go to IDLE on the next edge. The counter, `active_dir`, latches, and flash phase are cleared.
- Precedence: rst_n > `en`=0 > phase end > tick decrement.

## Timing
- Reset values: state IDLE, `light`=0, `walk`=0, `active_dir`=0, `remain`=0, `phase_done`=0, latches 0.
- Transitions take effect on the clk edge that ends the phase. New lamp values are visible in the following cycle.
- A phase of duration N lasts exactly N ticks after its entry edge.
- `remain` equals the counter value and is valid in every cycle.
- `ped_req` set in the same cycle as the GREEN-entry edge of that approach is serviced in that GREEN.
- Lamp invariant: at most one approach is non-R outside FLASH. Exactly one of G/Y/R is set per approach outside IDLE/FLASH. Bench asserts this every cycle.
- Asserting reset mid-phase clears all outputs asynchronously. Release resumes from IDLE.

## Test plan
All scenarios use `NUM_DIR`=2.
- Basic cycle (`en`=1; green=3, yellow=1, allred=1; tick every 4 cycles):
  - Phases: dir0 G for 3 ticks, Y for 1, all-R for 1, then dir1 G. `phase_done` pulses at each boundary; `active_dir` wraps 1→0.
- Zero durations (`yellow_time`=0, `allred_time`=0): each phase lasts exactly 1 tick and the lamp invariant holds.
- Pedestrian requests:
  - Pulse `ped_req[1]` during dir0 GREEN → `walk[1]`=1 for all of dir1 GREEN, `walk[0]`=0, and the latch clears.
  - A second pulse during dir1 GREEN → serviced at dir1's next GREEN.
- Night mode (`night_mode`=1 during dir0 GREEN):
  - Dir0 completes G→Y→ALL_RED, then FLASH with Y toggling every 2 ticks.
  - Drop `night_mode` → ALL_RED, then dir0 GREEN.
- Enable drop (`en`=0 mid-YELLOW): next cycle all outputs 0, IDLE. Re-raise `en` → dir0 GREEN one cycle later.
- Reset while a latch is pending and `remain`=2: outputs immediately 0. After release and `en`=1, no `walk` is asserted.
